long_op_scoreboard: RTL



---
 rtl/long_op_scoreboard.sv | 117 +++++++++++
 1 files changed

// File: rtl/long_op_scoreboard.sv
// Pending-write scoreboard and register-file write-port arbiter for the
// multicycle unit: hazard stalls, LU issue/writeback control, starvation guard.
//
// state  | meaning
// IDLE   | no LU ops outstanding
// ACTIVE | LU ops outstanding, writebacks flowing
// STARVE | LU result waited too long; pipeline frozen until it is granted
module long_op_scoreboard #(
  parameter int MAX_PENDING  = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs_id,
  input  logic [4:0]  rt_id,
  input  logic        use_rs_id,
  input  logic        use_rt_id,
  input  logic [4:0]  dst_id,
  input  logic        regwrite_id,
  input  logic        issue_long,
  input  logic        lu_ready,
  input  logic        flush,
  input  logic        regwrite_wb,
  input  logic        lu_wb_req,
  input  logic [4:0]  lu_wb_dst,
  output logic        issue_fire,
  output logic        lu_wb_grant,
  output logic        ifid_write,
  output logic        pcwrite,
  output logic        hazard,
  output logic [31:0] busy,
  output logic [3:0]  pending_cnt,
  output logic [1:0]  sb_state,
  output logic        err
);

  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_ACTIVE = 2'b01;
  localparam logic [1:0] S_STARVE = 2'b10;

  localparam logic [3:0] MAX_P   = 4'(MAX_PENDING);
  localparam logic [3:0] STARVE_L = 4'(STARVE_LIMIT);

  logic [31:0] busy_q, busy_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  wait_q, wait_d;
  logic [1:0]  st_q, st_d;
  logic        err_q, err_d;
  logic        raw, waw, structural, stall;

  always_comb begin
    raw        = (use_rs_id & busy_q[rs_id]) | (use_rt_id & busy_q[rt_id]);
    waw        = regwrite_id & (dst_id != 5'd0) & busy_q[dst_id];
    structural = issue_long & ((cnt_q == MAX_P) | ~lu_ready);
    stall      = raw | waw | structural | (st_q == S_STARVE);
  end

  assign hazard      = stall;
  assign ifid_write  = ~stall;
  assign pcwrite     = ~stall;
  assign issue_fire  = issue_long & ~stall & ~flush;
  assign lu_wb_grant = lu_wb_req & ~regwrite_wb;

  assign busy        = busy_q;
  assign pending_cnt = cnt_q;
  assign sb_state    = st_q;
  assign err         = err_q;

  always_comb begin
    busy_d = busy_q;
    if (lu_wb_grant) busy_d[lu_wb_dst] = 1'b0;
    if (issue_fire && regwrite_id && (dst_id != 5'd0)) busy_d[dst_id] = 1'b1;
    busy_d[0] = 1'b0;

    cnt_d = cnt_q;
    err_d = err_q;
    if (issue_fire && !lu_wb_grant) begin
      cnt_d = cnt_q + 4'd1;
    end else if (lu_wb_grant && !issue_fire && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
    // a writeback with nothing outstanding means the LU and scoreboard disagree
    if (lu_wb_grant && (cnt_q == 4'd0)) err_d = 1'b1;

    if (!lu_wb_req || lu_wb_grant) wait_d = 4'd0;
    else if (wait_q != 4'hF)       wait_d = wait_q + 4'd1;
    else                           wait_d = wait_q;

    st_d = st_q;
    case (st_q)
      S_IDLE:   if (issue_fire) st_d = S_ACTIVE;
      S_ACTIVE: begin
        if (cnt_d == 4'd0)           st_d = S_IDLE;
        else if (wait_d >= STARVE_L) st_d = S_STARVE;
      end
      S_STARVE: if (lu_wb_grant) st_d = (cnt_d == 4'd0) ? S_IDLE : S_ACTIVE;
      default:  st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 32'd0;
      cnt_q  <= 4'd0;
      wait_q <= 4'd0;
      st_q   <= S_IDLE;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      wait_q <= wait_d;
      st_q   <= st_d;
      err_q  <= err_d;
    end
  end

endmodule
